// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU sequencer: FSM states and
// decoder func/opcode values.
package cpu_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    localparam logic [2:0] FUNC_CTRL = 3'b000;
    localparam logic [2:0] FUNC_ALU  = 3'b001;
    localparam logic [2:0] FUNC_MEM  = 3'b010;
    localparam logic [2:0] FUNC_BR   = 3'b011;

    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_HALT  = 3'b111;

    // A wait counter needs to hold 0..limit-1, with at least one bit.
    function automatic int timeout_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cpu_seq_ctrl_bus_timeout.sv
// Wait-cycle counter shared by the FETCH and MEM handshakes; expired flags
// the last permitted cycle without an ack.
module bus_timeout #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          tick,
    input  logic [TW-1:0] limit,
    output logic          expired
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // The cycle that would take the count to the limit is the expiring one.
    assign expired = tick && (cnt_q >= (limit - TW'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick && !expired) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer with imem/dmem
// handshakes, bus timeout, and a retired-instruction counter.
//
//  state  | meaning
//  IDLE   | waiting for start after reset
//  FETCH  | imem_req held until imem_ack; ir_load on the ack cycle
//  DECODE | one cycle for decoder outputs to settle; halt check
//  EXEC   | alu_en; branches and nops retire here
//  MEM    | dmem_req held until dmem_ack; stores retire here
//  WB     | register write and PC advance
//  HALT   | parked on halt word until start
//  ERROR  | bus timeout; sticky until reset
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_load,
    input  logic             dec_halt,
    input  logic [2:0]       dec_func,
    input  logic [2:0]       dec_opcode,
    input  logic             br_taken,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic             pc_en,
    output logic             pc_st_flag,
    output logic             pc_we,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             halted,
    output logic             bus_error,
    output logic [2:0]       state
);

    localparam int TW = timeout_width(MEM_TIMEOUT);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] retired_d;
    logic             to_clear;
    logic             to_tick;
    logic             to_expired;

    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        alu_en     = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        pc_we      = 1'b0;
        pc_st_flag = 1'b0;
        halted     = 1'b0;
        bus_error  = 1'b0;
        to_tick    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                to_tick  = !imem_ack;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (to_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                state_d = dec_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                alu_en = 1'b1;
                case (dec_func)
                    FUNC_ALU: state_d = S_WB;
                    FUNC_MEM: state_d = S_MEM;
                    FUNC_BR: begin
                        pc_we      = 1'b1;
                        pc_st_flag = br_taken;
                        state_d    = S_FETCH;
                    end
                    default: begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (dec_opcode == OP_STORE);
                to_tick  = !dmem_ack;
                if (dmem_ack) begin
                    if (dmem_we) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (to_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                // Resuming steps the PC past the halt word.
                if (start) begin
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                bus_error = 1'b1;
            end
        endcase
    end

    assign pc_en       = pc_we;
    assign to_clear    = (state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM));
    assign retired_d   = pc_we ? (retired_q + CNT_W'(1)) : retired_q;
    assign retired_cnt = retired_q;
    assign state       = state_q;

    bus_timeout #(
        .TW(TW)
    ) u_bus_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (to_clear),
        .tick   (to_tick),
        .limit  (TW'(MEM_TIMEOUT)),
        .expired(to_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl with MEM_TIMEOUT=4 and a 3-bit retired
// counter so the wrap from 7 to 0 is reachable.
module tb_cpu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       imem_req;
    logic       imem_ack;
    logic       ir_load;
    logic       dec_halt;
    logic [2:0] dec_func;
    logic [2:0] dec_opcode;
    logic       br_taken;
    logic       alu_en;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic       rf_we;
    logic       pc_en;
    logic       pc_st_flag;
    logic       pc_we;
    logic [2:0] retired_cnt;
    logic       halted;
    logic       bus_error;
    logic [2:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cpu_seq_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .ir_load    (ir_load),
        .dec_halt   (dec_halt),
        .dec_func   (dec_func),
        .dec_opcode (dec_opcode),
        .br_taken   (br_taken),
        .alu_en     (alu_en),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .rf_we      (rf_we),
        .pc_en      (pc_en),
        .pc_st_flag (pc_st_flag),
        .pc_we      (pc_we),
        .retired_cnt(retired_cnt),
        .halted     (halted),
        .bus_error  (bus_error),
        .state      (state)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed just after the edge and the
    // outputs are sampled 1 ns later, well clear of both edges.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_instr(input logic [2:0] f, input logic [2:0] op, input logic h);
        dec_func   = f;
        dec_opcode = op;
        dec_halt   = h;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        dec_halt = 1'b0; dec_func = 3'b000; dec_opcode = 3'b000; br_taken = 1'b0;
        #12;
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_imem_req", 8'(imem_req), 8'd0);
        chk("rst_retired", 8'(retired_cnt), 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_no_start", 8'(state), 8'd0);

        // ALU instruction, imem_ack one cycle after the request.
        start = 1'b1; tick(); start = 1'b0; settle();
        chk("fetch_state", 8'(state), 8'd1);
        chk("fetch_req", 8'(imem_req), 8'd1);
        chk("fetch_noack_irload", 8'(ir_load), 8'd0);
        tick();
        imem_ack = 1'b1; set_instr(3'b001, 3'b000, 1'b0); settle();
        chk("fetch_irload", 8'(ir_load), 8'd1);
        tick(); imem_ack = 1'b0; settle();
        chk("decode_state", 8'(state), 8'd2);
        chk("decode_req", 8'(imem_req), 8'd0);
        tick();
        chk("exec_alu_en", 8'(alu_en), 8'd1);
        chk("exec_alu_pcwe", 8'(pc_we), 8'd0);
        tick();
        chk("wb_state", 8'(state), 8'd5);
        chk("wb_rf_we", 8'(rf_we), 8'd1);
        chk("wb_pc_we", 8'(pc_we), 8'd1);
        chk("wb_pc_en", 8'(pc_en), 8'd1);
        chk("wb_st_flag", 8'(pc_st_flag), 8'd0);
        tick();
        chk("alu_back_fetch", 8'(state), 8'd1);
        chk("alu_retired", 8'(retired_cnt), 8'd1);

        // Load: dmem_req held three cycles, ack on the third.
        imem_ack = 1'b1; set_instr(3'b010, 3'b000, 1'b0); tick(); imem_ack = 1'b0;
        tick();
        tick();
        chk("mem_state", 8'(state), 8'd4);
        chk("load_req_c1", 8'(dmem_req), 8'd1);
        chk("load_we", 8'(dmem_we), 8'd0);
        tick();
        chk("load_req_c2", 8'(dmem_req), 8'd1);
        tick();
        dmem_ack = 1'b1; settle();
        chk("load_req_c3", 8'(dmem_req), 8'd1);
        chk("load_ack_pcwe", 8'(pc_we), 8'd0);
        tick(); dmem_ack = 1'b0; settle();
        chk("load_wb_state", 8'(state), 8'd5);
        chk("load_wb_rfwe", 8'(rf_we), 8'd1);
        tick();
        chk("load_retired", 8'(retired_cnt), 8'd2);

        // Store: retires straight from MEM.
        imem_ack = 1'b1; set_instr(3'b010, 3'b001, 1'b0); tick(); imem_ack = 1'b0;
        tick(); tick();
        dmem_ack = 1'b1; settle();
        chk("store_we", 8'(dmem_we), 8'd1);
        chk("store_pcwe", 8'(pc_we), 8'd1);
        chk("store_rfwe", 8'(rf_we), 8'd0);
        tick(); dmem_ack = 1'b0; settle();
        chk("store_back_fetch", 8'(state), 8'd1);
        chk("store_retired", 8'(retired_cnt), 8'd3);

        // Branch taken then not taken, then a nop.
        imem_ack = 1'b1; set_instr(3'b011, 3'b000, 1'b0); br_taken = 1'b1;
        tick(); imem_ack = 1'b0; tick();
        chk("br_t_pcwe", 8'(pc_we), 8'd1);
        chk("br_t_st_flag", 8'(pc_st_flag), 8'd1);
        tick();
        chk("br_t_fetch", 8'(state), 8'd1);
        imem_ack = 1'b1; br_taken = 1'b0; tick(); imem_ack = 1'b0; tick();
        chk("br_nt_pcwe", 8'(pc_we), 8'd1);
        chk("br_nt_st_flag", 8'(pc_st_flag), 8'd0);
        tick();
        chk("br_retired", 8'(retired_cnt), 8'd5);
        imem_ack = 1'b1; set_instr(3'b000, 3'b000, 1'b0); tick(); imem_ack = 1'b0; tick();
        chk("nop_pcwe", 8'(pc_we), 8'd1);
        tick();
        chk("nop_retired", 8'(retired_cnt), 8'd6);

        // Halt, dwell, resume with start.
        imem_ack = 1'b1; set_instr(3'b000, 3'b111, 1'b1); tick(); imem_ack = 1'b0; settle();
        chk("halt_decode_pcwe", 8'(pc_we), 8'd0);
        tick();
        chk("halt_state", 8'(state), 8'd6);
        chk("halt_flag", 8'(halted), 8'd1);
        tick();
        chk("halt_dwell", 8'(state), 8'd6);
        chk("halt_no_retire", 8'(retired_cnt), 8'd6);
        start = 1'b1; settle();
        chk("halt_start_pcwe", 8'(pc_we), 8'd1);
        tick(); start = 1'b0; settle();
        chk("halt_resume_fetch", 8'(state), 8'd1);
        chk("halt_retired", 8'(retired_cnt), 8'd7);
        chk("halt_cleared", 8'(halted), 8'd0);

        // imem_ack on the 4th wait cycle still wins; retire wraps 7 -> 0.
        set_instr(3'b001, 3'b000, 1'b0);
        tick(); tick(); tick();
        imem_ack = 1'b1; settle();
        chk("lim_ack_irload", 8'(ir_load), 8'd1);
        tick(); imem_ack = 1'b0; settle();
        chk("lim_ack_decode", 8'(state), 8'd2);
        chk("lim_ack_no_err", 8'(bus_error), 8'd0);
        tick(); tick(); tick();
        chk("retired_wrap", 8'(retired_cnt), 8'd0);

        // No imem_ack: four wait cycles then ERROR, sticky.
        chk("to_fetch", 8'(state), 8'd1);
        tick(); tick(); tick();
        chk("to_still_fetch", 8'(state), 8'd1);
        tick();
        chk("to_error_state", 8'(state), 8'd7);
        chk("to_bus_error", 8'(bus_error), 8'd1);
        chk("to_err_req", 8'(imem_req), 8'd0);
        imem_ack = 1'b1; start = 1'b1;
        tick(); tick();
        chk("err_sticky", 8'(state), 8'd7);
        chk("err_no_irload", 8'(ir_load), 8'd0);
        imem_ack = 1'b0; start = 1'b0;

        // Reset out of ERROR, retire one ALU op, then reset mid-MEM.
        rst_n = 1'b0; settle();
        chk("err_rst_clear", 8'(bus_error), 8'd0);
        tick(); rst_n = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        imem_ack = 1'b1; set_instr(3'b001, 3'b000, 1'b0); tick(); imem_ack = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst_retired", 8'(retired_cnt), 8'd1);
        imem_ack = 1'b1; set_instr(3'b010, 3'b000, 1'b0); tick(); imem_ack = 1'b0;
        tick(); tick();
        chk("pre_rst_dmem_req", 8'(dmem_req), 8'd1);
        rst_n = 1'b0; settle();
        chk("rst_mem_dmem_req", 8'(dmem_req), 8'd0);
        chk("rst_mem_imem_req", 8'(imem_req), 8'd0);
        chk("rst_mem_state", 8'(state), 8'd0);
        chk("rst_mem_retired", 8'(retired_cnt), 8'd0);
        tick(); rst_n = 1'b1; tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
